uart_tx_port: RTL and testbench

CPU-bus-addressed serial transmitter for the 8088 system: a bus responder that accepts bytes written by the CPU over the decoded I/O strobes, buffers them in a small FIFO, and shifts them out as 8N1 asynchronous serial on `txd`. It sits beside the PIC/PIT/PPI on the system bus and drives a level interrupt request into one PIC IR input.

---
 rtl/uart_tx_pkg.sv | 33 +++
 rtl/uart_tx_port_fifo.sv | 76 +++++++
 rtl/uart_tx_port.sv | 210 +++++++++++++++++++++
 tb/tb_uart_tx_port.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the bus-attached UART transmitter: register map,
// status/control bit positions, transmitter state encoding and baud divisor.
package uart_tx_pkg;

  // Register select values on the single address line
  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STAT = 1'b1;

  // Bit positions inside the status byte returned from REG_STAT
  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVR   = 3;
  localparam int STAT_IEN   = 4;

  // Bit positions inside the control byte written to REG_STAT
  localparam int CTRL_IEN   = 0;
  localparam int CTRL_FLUSH = 1;

  // Serial framing states: one start bit, eight data bits, one stop bit
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Clocks per serial bit, rounded to the nearest integer
  function automatic int calcDiv(input int clkHz, input int baud);
    return (clkHz + (baud / 2)) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_port_fifo.sv
// Small synchronous FIFO buffering bytes between the CPU bus and the
// serial shifter. Flush has priority over push and pop in the same cycle.
module sync_fifo
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_doPop;
  logic w_doPush;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push
  assign w_doPop    = i_pop & ~w_empty & ~i_flush;
  assign w_doPush   = i_push & ~i_flush & (~w_full | w_doPop);
  assign o_overflow = i_push & ~i_flush & w_full & ~w_doPop;

  assign o_data  = r_mem[r_rdPtr];
  assign o_count = r_count;

  // Storage array; contents need no reset because the count guards reads
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping, pointers wrap on the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// CPU-bus serial transmitter: edge-detects the bus strobes, holds the
// control/status registers, buffers bytes in a FIFO and shifts them out 8N1.
module uart_tx_port
  import uart_tx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       a,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  output logic       txd
);

  localparam int DIV     = calcDiv(CLK_HZ, BAUD);
  localparam int TIMER_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic               r_wrTermQ;
  logic               r_rdTermQ;
  logic               r_ien;
  logic               r_ovr;
  logic [7:0]         r_dout;
  tx_state_e          r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [2:0]         r_bitCnt;
  logic [7:0]         r_shift;
  logic               r_txd;

  logic               w_wrTerm;
  logic               w_rdTerm;
  logic               w_wrEvent;
  logic               w_rdEvent;
  logic               w_push;
  logic               w_ctrlWr;
  logic               w_flush;
  logic               w_pop;
  logic               w_timerDone;
  logic               w_busy;
  logic [7:0]         w_fifoData;
  logic [CNT_W-1:0]   w_fifoCount;
  logic               w_fifoFull;
  logic               w_fifoEmpty;
  logic               w_overflow;
  logic [7:0]         w_status;

  // Strobe terms; an event is the first cycle a term is seen true
  assign w_wrTerm  = ~cs_n & ~wr_n;
  assign w_rdTerm  = ~cs_n & ~rd_n;
  assign w_wrEvent = w_wrTerm & ~r_wrTermQ;
  assign w_rdEvent = w_rdTerm & ~r_rdTermQ;

  assign w_push   = w_wrEvent & (a == REG_DATA);
  assign w_ctrlWr = w_wrEvent & (a == REG_STAT);
  assign w_flush  = w_ctrlWr & din[CTRL_FLUSH];

  assign w_fifoFull  = (w_fifoCount == CNT_W'(FIFO_DEPTH));
  assign w_fifoEmpty = (w_fifoCount == '0);

  assign w_busy      = (r_state != ST_IDLE);
  assign w_timerDone = (r_timer == TIMER_W'(DIV - 1));

  // Load the shifter from idle, or straight from the last stop-bit clock so
  // consecutive frames have no idle gap; a flush in the same cycle suppresses it
  assign w_pop = ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_timerDone))
                 & ~w_fifoEmpty & ~w_flush;

  assign irq  = r_ien & w_fifoEmpty & ~w_busy;
  assign dout = r_dout;
  assign txd  = r_txd;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .i_data     (din),
    .o_data     (w_fifoData),
    .o_count    (w_fifoCount),
    .o_overflow (w_overflow)
  );

  // Assemble the status byte from the named bit positions
  always_comb begin
    w_status              = 8'h00;
    w_status[STAT_BUSY]   = w_busy;
    w_status[STAT_FULL]   = w_fifoFull;
    w_status[STAT_EMPTY]  = w_fifoEmpty;
    w_status[STAT_OVR]    = r_ovr;
    w_status[STAT_IEN]    = r_ien;
  end

  // Remember last cycle's strobe terms so long strobes yield a single event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrTermQ <= 1'b0;
      r_rdTermQ <= 1'b0;
    end else begin
      r_wrTermQ <= w_wrTerm;
      r_rdTermQ <= w_rdTerm;
    end
  end

  // Interrupt enable from control writes; overrun sticky until a read event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ien <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (w_ctrlWr) begin
        r_ien <= din[CTRL_IEN];
      end
      if (w_rdEvent) begin
        r_ovr <= 1'b0;
      end
      if (w_overflow) begin
        r_ovr <= 1'b1;
      end
    end
  end

  // Read data tracks the register select every cycle; data reads return zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= 8'h00;
    end else begin
      r_dout <= (a == REG_STAT) ? w_status : 8'h00;
    end
  end

  // Framing FSM with bit timer, bit counter, shifter and registered line output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_txd    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_txd   <= 1'b1;
          r_timer <= '0;
          if (w_pop) begin
            r_shift <= w_fifoData;
            r_txd   <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_timerDone) begin
            r_timer  <= '0;
            r_bitCnt <= '0;
            r_txd    <= r_shift[0];
            r_shift  <= {1'b0, r_shift[7:1]};
            r_state  <= ST_DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_timerDone) begin
            r_timer <= '0;
            if (r_bitCnt == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
              r_txd    <= r_shift[0];
              r_shift  <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_timerDone) begin
            r_timer <= '0;
            if (w_pop) begin
              r_shift <= w_fifoData;
              r_txd   <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_txd   <= 1'b1;
          r_timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port: a serial monitor decodes every frame and
// compares it with bytes queued by the stimulus; bus reads and line timing
// are compared inline against hand-computed values.
module tb_uart_tx_port;

  localparam int DIV = 434;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       a;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;
  logic       txd;

  int         vectors = 0;
  int         miscompares = 0;
  int         cycleCnt = 0;
  int         lastFallCycle = -1;
  int         resetEpoch = 0;
  int         evtCycle = 0;
  logic       prevTxd = 1'b1;
  logic       monBusy = 1'b0;
  logic [7:0] lastRead;
  logic [7:0] expQ[$];

  uart_tx_port #(
    .CLK_HZ     (50_000_000),
    .BAUD       (115200),
    .FIFO_DEPTH (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cs_n  (cs_n),
    .wr_n  (wr_n),
    .rd_n  (rd_n),
    .a     (a),
    .din   (din),
    .dout  (dout),
    .irq   (irq),
    .txd   (txd)
  );

  // Free-running clock and a cycle counter used as the bench time base
  initial forever #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Record the cycle of every falling edge on the line
  always @(negedge clk) begin
    if (prevTxd === 1'b1 && txd === 1'b0) lastFallCycle = cycleCnt;
    prevTxd = txd;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One bus access: strobe asserted for len cycles; read data captured after
  // the first sampling edge
  task automatic applyStimulus(input logic isWrite, input logic addr,
                               input logic [7:0] data, input int len);
    @(negedge clk);
    cs_n = 1'b0;
    a    = addr;
    din  = data;
    if (isWrite) wr_n = 1'b0;
    else         rd_n = 1'b0;
    evtCycle = cycleCnt;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) lastRead = dout;
    end
    cs_n = 1'b1;
    wr_n = 1'b1;
    rd_n = 1'b1;
  endtask

  task automatic readStatus(input string name, input logic [7:0] expected);
    applyStimulus(1'b0, 1'b1, 8'h00, 1);
    checkOutput(name, lastRead, expected);
  endtask

  task automatic waitUntilCycle(input int target);
    while (cycleCnt < target) @(negedge clk);
  endtask

  // Serial monitor: samples mid-bit and scores each frame against the queue
  initial begin : monitor
    logic [7:0] rxByte;
    logic       startBit;
    logic       stopBit;
    int         epoch;
    rxByte = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        monBusy = 1'b1;
        epoch   = resetEpoch;
        repeat (DIV / 2) @(negedge clk);
        startBit = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          rxByte[i] = txd;
        end
        repeat (DIV) @(negedge clk);
        stopBit = txd;
        if (epoch == resetEpoch) begin
          checkOutput("start bit", {31'b0, startBit}, 32'h0);
          checkOutput("stop bit", {31'b0, stopBit}, 32'h1);
          if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected frame: got 0x%02h, expected no frame", rxByte);
          end else begin
            checkOutput("frame data", {24'b0, rxByte}, {24'b0, expQ.pop_front()});
          end
        end
        monBusy = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int f;
    int evt1;
    rst_n = 1'b1;
    cs_n  = 1'b1;
    wr_n  = 1'b1;
    rd_n  = 1'b1;
    a     = 1'b0;
    din   = 8'h00;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset txd", {31'b0, txd}, 32'h1);
    checkOutput("reset dout", {24'b0, dout}, 32'h0);
    checkOutput("reset irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    readStatus("status after reset", 8'h04);

    // Single 0x55 with a 4-clock strobe: one frame, start 2 clocks after event
    lastFallCycle = -1;
    expQ.push_back(8'h55);
    applyStimulus(1'b1, 1'b0, 8'h55, 4);
    checkOutput("event to start latency", lastFallCycle - evtCycle, 32'd2);
    f = lastFallCycle;
    readStatus("status mid frame", 8'h05);
    waitUntilCycle(f + 9 * DIV - 1);
    checkOutput("bit7 of 0x55", {31'b0, txd}, 32'h0);
    waitUntilCycle(f + 9 * DIV);
    checkOutput("stop bit start", {31'b0, txd}, 32'h1);
    waitUntilCycle(f + 10 * DIV);
    checkOutput("line idle after frame", {31'b0, txd}, 32'h1);
    readStatus("status after frame", 8'h04);

    // Three back-to-back frames with contiguous stop/start boundaries
    lastFallCycle = -1;
    expQ.push_back(8'h41);
    expQ.push_back(8'h42);
    expQ.push_back(8'h43);
    applyStimulus(1'b1, 1'b0, 8'h41, 1);
    evt1 = evtCycle;
    applyStimulus(1'b1, 1'b0, 8'h42, 1);
    applyStimulus(1'b1, 1'b0, 8'h43, 1);
    f = lastFallCycle;
    checkOutput("burst start latency", f - evt1, 32'd2);
    for (int k = 1; k <= 2; k++) begin
      waitUntilCycle(f + k * 10 * DIV - 1);
      checkOutput("stop before next start", {31'b0, txd}, 32'h1);
      waitUntilCycle(f + k * 10 * DIV);
      checkOutput("next start contiguous", {31'b0, txd}, 32'h0);
    end
    waitUntilCycle(f + 30 * DIV - 1);
    checkOutput("third stop bit", {31'b0, txd}, 32'h1);
    waitUntilCycle(f + 30 * DIV);
    readStatus("status after burst", 8'h04);

    // Eighteen quick writes: one goes to the shifter, sixteen fill the FIFO,
    // the last is dropped and sets overrun
    lastFallCycle = -1;
    expQ.push_back(8'h60);
    for (int k = 0; k < 18; k++) applyStimulus(1'b1, 1'b0, 8'h60 + 8'(k), 1);
    f = lastFallCycle;
    readStatus("status overrun full", 8'h0B);
    readStatus("status overrun cleared", 8'h03);
    applyStimulus(1'b1, 1'b1, 8'h02, 1);
    readStatus("status after flush", 8'h05);
    waitUntilCycle(f + 10 * DIV + 1);
    readStatus("status after flushed frame", 8'h04);

    // Interrupt enable, drop on push, rise when the stop bit ends
    checkOutput("irq with ien off", {31'b0, irq}, 32'h0);
    applyStimulus(1'b1, 1'b1, 8'h01, 1);
    checkOutput("irq after enable", {31'b0, irq}, 32'h1);
    lastFallCycle = -1;
    expQ.push_back(8'h3C);
    applyStimulus(1'b1, 1'b0, 8'h3C, 1);
    checkOutput("irq after push", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    f = lastFallCycle;
    checkOutput("irq frame start latency", f - evtCycle, 32'd2);
    waitUntilCycle(f + 10 * DIV - 1);
    checkOutput("irq during stop", {31'b0, irq}, 32'h0);
    waitUntilCycle(f + 10 * DIV);
    checkOutput("irq after stop", {31'b0, irq}, 32'h1);

    // Five bytes queued, flush mid-frame: only the byte in the shifter goes out
    lastFallCycle = -1;
    for (int k = 0; k < 5; k++) begin
      expQ.push_back(8'hA1 + 8'(k));
      applyStimulus(1'b1, 1'b0, 8'hA1 + 8'(k), 1);
    end
    f = lastFallCycle;
    repeat (500) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'h03, 1);
    while (expQ.size() > 1) void'(expQ.pop_back());
    readStatus("status flush mid frame", 8'h15);
    waitUntilCycle(f + 10 * DIV);
    checkOutput("irq after flushed frame", {31'b0, irq}, 32'h1);
    waitUntilCycle(f + 12 * DIV);
    checkOutput("no frame after flush", {31'b0, txd}, 32'h1);
    readStatus("status drained", 8'h14);

    // Reset in the middle of a zero data bit
    lastFallCycle = -1;
    applyStimulus(1'b1, 1'b0, 8'hF0, 1);
    repeat (3) @(negedge clk);
    f = lastFallCycle;
    waitUntilCycle(f + 2 * DIV + 100);
    checkOutput("txd in data bit", {31'b0, txd}, 32'h0);
    rst_n = 1'b0;
    resetEpoch++;
    #1;
    checkOutput("txd async reset", {31'b0, txd}, 32'h1);
    checkOutput("dout async reset", {24'b0, dout}, 32'h0);
    checkOutput("irq async reset", {31'b0, irq}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    readStatus("status after mid-frame reset", 8'h04);

    // Let the monitor finish and the scoreboard empty
    for (int i = 0; i < 12 * DIV && (monBusy || expQ.size() != 0); i++) @(negedge clk);
    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    checkOutput("monitor idle", {31'b0, monBusy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
